// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter for ALU and LSB results

// Per-source result FIFO. Flush wins over the ready hold, which wins over
// normal push/pop. Storage is not reset; only pointers and count are.
module cdb_arbiter_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign head_data = mem[head];

  // Storage write; only the entry at the tail is touched on an accepted push.
  always_ff @(posedge clk_in) begin
    if (rst_in && !flush && rdy_in && wr_en) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (wr_en) begin
        tail <= tail + 1'b1;
      end
      if (rd_en) begin
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// Arbiter top: two result FIFOs with empty-FIFO bypass, a round-robin grant
// and a registered broadcast. last_grant = 1 means the LSB won last.
module cdb_arbiter #(
  parameter int ROB_W = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear_up,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_entry,
  input  logic [31:0]      alu_value,
  output logic             alu_full,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_rob_entry,
  input  logic [31:0]      lsb_value,
  output logic             lsb_full,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_entry,
  output logic [31:0]      cdb_value,
  output logic             cdb_src,
  output logic             overflow
);

  localparam int DW = ROB_W + 32;

  logic [CNT_W-1:0] alu_cnt;
  logic [CNT_W-1:0] lsb_cnt;
  logic [DW-1:0]    alu_head;
  logic [DW-1:0]    lsb_head;
  logic [DW-1:0]    alu_in;
  logic [DW-1:0]    lsb_in;
  logic             alu_empty;
  logic             lsb_empty;
  logic             alu_cand;
  logic             lsb_cand;
  logic [DW-1:0]    alu_cand_data;
  logic [DW-1:0]    lsb_cand_data;
  logic             grant_alu;
  logic             grant_lsb;
  logic             alu_wr;
  logic             lsb_wr;
  logic             alu_rd;
  logic             lsb_rd;
  logic             last_grant;
  logic [DW-1:0]    win_data;

  assign alu_in = {alu_rob_entry, alu_value};
  assign lsb_in = {lsb_rob_entry, lsb_value};

  // Full flags come from the registered count only, so producers see a
  // stable backpressure signal for the whole cycle.
  assign alu_empty = (alu_cnt == '0);
  assign lsb_empty = (lsb_cnt == '0);
  assign alu_full  = (alu_cnt == CNT_W'(DEPTH));
  assign lsb_full  = (lsb_cnt == CNT_W'(DEPTH));

  // Candidate selection and round-robin grant. An empty FIFO offers the
  // incoming push directly so an uncontested result costs one cycle.
  always_comb begin
    alu_cand      = !alu_empty || alu_valid;
    lsb_cand      = !lsb_empty || lsb_valid;
    alu_cand_data = alu_empty ? alu_in : alu_head;
    lsb_cand_data = lsb_empty ? lsb_in : lsb_head;
    grant_lsb     = lsb_cand && (!alu_cand || !last_grant);
    grant_alu     = alu_cand && !grant_lsb;
    win_data      = grant_lsb ? lsb_cand_data : alu_cand_data;
    alu_rd        = grant_alu && !alu_empty;
    lsb_rd        = grant_lsb && !lsb_empty;
    alu_wr        = alu_valid && !alu_full && !(alu_empty && grant_alu);
    lsb_wr        = lsb_valid && !lsb_full && !(lsb_empty && grant_lsb);
  end

  cdb_arbiter_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_alu_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush    (rob_clear_up),
    .wr_en    (alu_wr),
    .wr_data  (alu_in),
    .rd_en    (alu_rd),
    .head_data(alu_head),
    .count    (alu_cnt)
  );

  cdb_arbiter_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_lsb_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush    (rob_clear_up),
    .wr_en    (lsb_wr),
    .wr_data  (lsb_in),
    .rd_en    (lsb_rd),
    .head_data(lsb_head),
    .count    (lsb_cnt)
  );

  // Sticky overflow: any push presented against a full FIFO while running.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overflow <= 1'b0;
    end else if (!rob_clear_up && rdy_in) begin
      if ((alu_valid && alu_full) || (lsb_valid && lsb_full)) begin
        overflow <= 1'b1;
      end
    end
  end

  // Registered broadcast; payload holds when nothing is granted so only
  // cdb_valid drops. Flush points the tie-break back at the ALU.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid     <= 1'b0;
      cdb_rob_entry <= '0;
      cdb_value     <= '0;
      cdb_src       <= 1'b0;
      last_grant    <= 1'b1;
    end else if (rob_clear_up) begin
      cdb_valid  <= 1'b0;
      last_grant <= 1'b1;
    end else if (rdy_in) begin
      if (grant_alu || grant_lsb) begin
        cdb_valid     <= 1'b1;
        cdb_rob_entry <= win_data[DW-1:32];
        cdb_value     <= win_data[31:0];
        cdb_src       <= grant_lsb;
        last_grant    <= grant_lsb;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - table and scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int ROB_W = 5;
  localparam int DEPTH = 4;

  logic             clk_in;
  logic             rst_in;
  logic             rdy_in;
  logic             rob_clear_up;
  logic             alu_valid;
  logic [ROB_W-1:0] alu_rob_entry;
  logic [31:0]      alu_value;
  logic             alu_full;
  logic             lsb_valid;
  logic [ROB_W-1:0] lsb_rob_entry;
  logic [31:0]      lsb_value;
  logic             lsb_full;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_entry;
  logic [31:0]      cdb_value;
  logic             cdb_src;
  logic             overflow;

  cdb_arbiter #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .alu_valid    (alu_valid),
    .alu_rob_entry(alu_rob_entry),
    .alu_value    (alu_value),
    .alu_full     (alu_full),
    .lsb_valid    (lsb_valid),
    .lsb_rob_entry(lsb_rob_entry),
    .lsb_value    (lsb_value),
    .lsb_full     (lsb_full),
    .cdb_valid    (cdb_valid),
    .cdb_rob_entry(cdb_rob_entry),
    .cdb_value    (cdb_value),
    .cdb_src      (cdb_src),
    .overflow     (overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        av;
    logic [4:0]  ae;
    logic [31:0] aval;
    logic        lv;
    logic [4:0]  le;
    logic [31:0] lval;
    logic        ev;
    logic [4:0]  ee;
    logic [31:0] eval;
    logic        es;
  } vec_t;

  vec_t tbl [11];

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] aq [$];
  logic [36:0] lq [$];
  logic        exp_valid;
  logic [4:0]  exp_entry;
  logic [31:0] exp_value;
  logic        exp_src;
  logic        exp_ovf;
  logic        m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    exp_valid = 1'b0;
    exp_entry = '0;
    exp_value = '0;
    exp_src   = 1'b0;
    exp_ovf   = 1'b0;
    m_last    = 1'b1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ae, input logic [31:0] aval,
                       input logic lv, input logic [4:0] le, input logic [31:0] lval);
    alu_valid     = av;
    alu_rob_entry = ae;
    alu_value     = aval;
    lsb_valid     = lv;
    lsb_rob_entry = le;
    lsb_value     = lval;
  endtask

  // Scoreboard step: queue accepted pushes, pop the expected winner, clock
  // one edge, then compare every output at the falling edge.
  task automatic cycle();
    logic [36:0] w;
    logic ac, lc, win;
    if (rob_clear_up) begin
      aq.delete();
      lq.delete();
      exp_valid = 1'b0;
      m_last    = 1'b1;
    end else if (rdy_in) begin
      if (alu_valid) begin
        if (aq.size() == DEPTH) exp_ovf = 1'b1;
        else aq.push_back({alu_rob_entry, alu_value});
      end
      if (lsb_valid) begin
        if (lq.size() == DEPTH) exp_ovf = 1'b1;
        else lq.push_back({lsb_rob_entry, lsb_value});
      end
      ac = (aq.size() != 0);
      lc = (lq.size() != 0);
      if (ac || lc) begin
        win = (ac && lc) ? ~m_last : lc;
        if (win) w = lq.pop_front();
        else     w = aq.pop_front();
        exp_valid = 1'b1;
        exp_entry = w[36:32];
        exp_value = w[31:0];
        exp_src   = win;
        m_last    = win;
      end else begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    chk("cdb_valid", cdb_valid, exp_valid);
    chk("cdb_rob_entry", cdb_rob_entry, exp_entry);
    chk("cdb_value", cdb_value, exp_value);
    chk("cdb_src", cdb_src, exp_src);
    chk("alu_full", alu_full, aq.size() == DEPTH);
    chk("lsb_full", lsb_full, lq.size() == DEPTH);
    chk("overflow", overflow, exp_ovf);
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    tbl[0]  = '{1, 1,  32'h0A000001, 1, 11, 32'h0B00000B, 1, 1,  32'h0A000001, 0};
    tbl[1]  = '{1, 2,  32'h0A000002, 1, 12, 32'h0B00000C, 1, 11, 32'h0B00000B, 1};
    tbl[2]  = '{1, 3,  32'h0A000003, 1, 13, 32'h0B00000D, 1, 2,  32'h0A000002, 0};
    tbl[3]  = '{1, 4,  32'h0A000004, 1, 14, 32'h0B00000E, 1, 12, 32'h0B00000C, 1};
    tbl[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 3,  32'h0A000003, 0};
    tbl[5]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 13, 32'h0B00000D, 1};
    tbl[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 4,  32'h0A000004, 0};
    tbl[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 14, 32'h0B00000E, 1};
    tbl[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 14, 32'h0B00000E, 1};
    tbl[9]  = '{1, 3,  32'h000000AA, 0, 0,  32'h0,        1, 3,  32'h000000AA, 0};
    tbl[10] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 3,  32'h000000AA, 0};

    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    rob_clear_up = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    chk("reset_cdb_valid", cdb_valid, 0);
    chk("reset_alu_full", alu_full, 0);
    chk("reset_lsb_full", lsb_full, 0);
    chk("reset_overflow", overflow, 0);
    idle_cycles(1);

    // Round-robin contention followed by a single uncontested bypass.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].av, tbl[i].ae, tbl[i].aval, tbl[i].lv, tbl[i].le, tbl[i].lval);
      cycle();
      chk($sformatf("tbl%0d_valid", i), cdb_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_entry", i), cdb_rob_entry, tbl[i].ee);
      chk($sformatf("tbl%0d_value", i), cdb_value, tbl[i].eval);
      chk($sformatf("tbl%0d_src", i), cdb_src, tbl[i].es);
    end

    // LSB pushes blindly; ALU respects backpressure. LSB fills, then overflows.
    for (int i = 0; i < 9; i++) begin
      drive(aq.size() < DEPTH, 5'(i), 32'h1A00_0000 + i,
            1'b1, 5'(16 + i), 32'h1B00_0000 + i);
      cycle();
      if (i == 7) chk("lsb_full_rise", lsb_full, 1);
      if (i == 8) chk("overflow_set", overflow, 1);
    end
    idle_cycles(12);

    // Stall with ALU entries queued: pushes ignored, outputs frozen.
    drive(1, 20, 32'h2A000014, 1, 30, 32'h2B00001E); cycle();
    drive(1, 21, 32'h2A000015, 1, 31, 32'h2B00001F); cycle();
    drive(1, 22, 32'h2A000016, 0, 0, 0);             cycle();
    rdy_in = 1'b0;
    drive(1, 29, 32'h2A00001D, 1, 29, 32'h2B00001D);
    for (int i = 0; i < 3; i++) cycle();
    rdy_in = 1'b1;
    idle_cycles(8);

    // Flush with queued data and a concurrent push, rdy_in low to show it is ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(8 + i), 32'h3A000000 + i, 1, 5'(24 + i), 32'h3B000000 + i);
      cycle();
    end
    drive(1, 12, 32'h3A00000C, 0, 0, 0); cycle();
    rob_clear_up = 1'b1;
    rdy_in       = 1'b0;
    drive(0, 0, 0, 1, 27, 32'h3B00001B);
    cycle();
    rob_clear_up = 1'b0;
    rdy_in       = 1'b1;
    chk("flush_valid", cdb_valid, 0);
    chk("flush_overflow_kept", overflow, 1);
    idle_cycles(1);
    chk("flush_push_lost", cdb_valid, 0);
    drive(1, 6, 32'h4A000006, 1, 7, 32'h4B000007);
    cycle();
    chk("post_flush_src", cdb_src, 0);
    chk("post_flush_entry", cdb_rob_entry, 6);
    idle_cycles(3);

    // Asynchronous reset mid-cycle with data queued and a broadcast live.
    drive(1, 1, 32'h5A000001, 1, 2, 32'h5B000002); cycle();
    drive(1, 3, 32'h5A000003, 1, 4, 32'h5B000004); cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("async_cdb_valid", cdb_valid, 0);
    chk("async_cdb_entry", cdb_rob_entry, 0);
    chk("async_cdb_value", cdb_value, 0);
    chk("async_overflow", overflow, 0);
    chk("async_lsb_full", lsb_full, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
